sng_bitstream: RTL and testbench

- Stochastic number generator: converts an 8-bit unsigned value into a 255-bit unipolar stochastic bitstream.
- Each stream bit is produced by comparing the value against an 8-bit maximal-length LFSR.
- Feeds SC arithmetic such as the FPU mantissa multiplier, which ANDs two streams and counts ones once both generators report done.
- Instances use different LFSR seeds to decorrelate their streams.

---
 rtl/sc_pkg.sv | 16 +
 rtl/lfsr8.sv | 33 +++
 rtl/sng_bitstream.sv | 58 +++++
 tb/tb_sng_bitstream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared constants and helpers for the stochastic-computing blocks.
// The LFSR step function is the single definition of the stream sequence.
package sc_pkg;

  localparam int SBS_LEN = 255;
  localparam int LFSR_W  = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1 (state bits 7, 5, 4, 3).
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'b1011_1000;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR; loads seed on reset, steps when en is high.
module lfsr8
  import sc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] seed = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/sng_bitstream.sv
// Stochastic number generator: encodes a reset-sampled 8-bit value as a
// 255-bit unipolar stream by comparing it against a full-period LFSR.
module sng_bitstream
  import sc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] lfsr_seed = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LFSR_W-1:0]  a,
  output logic [SBS_LEN-1:0] a_sbs,
  output logic               done
);

  localparam logic [LFSR_W-1:0] LAST_IDX = LFSR_W'(SBS_LEN - 1);

  logic [LFSR_W-1:0]  lfsr_q;
  logic [LFSR_W-1:0]  a_q;
  logic [LFSR_W-1:0]  idx_q;
  logic [LFSR_W-1:0]  idx_d;
  logic [SBS_LEN-1:0] sbs_q;
  logic               done_q;
  logic               gen_en;
  logic               bit_d;

  assign gen_en = rst && !done_q;
  assign bit_d  = (lfsr_q <= a_q);
  assign idx_d  = idx_q + 8'd1;

  lfsr8 #(
    .seed(lfsr_seed)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en (gen_en),
    .q  (lfsr_q)
  );

  // a is only sampled while reset is held, so the stream encodes one value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= a;
      idx_q  <= '0;
      sbs_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      sbs_q[idx_q] <= bit_d;
      idx_q        <= idx_d;
      if (idx_q == LAST_IDX) begin
        done_q <= 1'b1;
      end
    end
  end

  assign a_sbs = sbs_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sng_bitstream.sv
// Self-checking bench for sng_bitstream: two instances with different seeds
// checked against a stream model built directly from the LFSR/compare rules.
module tb_sng_bitstream;

  logic         clk;
  logic         rst;
  logic [7:0]   a0;
  logic [7:0]   a1;
  logic [254:0] sbs0;
  logic [254:0] sbs1;
  logic         done0;
  logic         done1;

  int checks = 0;
  int errors = 0;

  sng_bitstream dut_a (
    .clk  (clk),
    .rst  (rst),
    .a    (a0),
    .a_sbs(sbs0),
    .done (done0)
  );

  sng_bitstream #(
    .lfsr_seed(8'h01)
  ) dut_b (
    .clk  (clk),
    .rst  (rst),
    .a    (a1),
    .a_sbs(sbs1),
    .done (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stream: bit i is (i-th LFSR value from seed) <= a.
  function automatic logic [254:0] model_stream(input logic [7:0] seed, input logic [7:0] val);
    logic [254:0] r;
    logic [7:0]   s;
    s = seed;
    r = '0;
    for (int i = 0; i < 255; i++) begin
      r[i] = (s <= val);
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] v0, input logic [7:0] v1);
    rst = 1'b0;
    a0  = v0;
    a1  = v1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(8'($urandom_range(255)), 8'($urandom_range(255)));
    checks++;
    if (done0 !== 1'b0 || sbs0 !== '0) begin
      errors++;
      $display("FAIL reset_a: done=%b sbs=%h want done=0 sbs=0", done0, sbs0);
    end
    checks++;
    if (done1 !== 1'b0 || sbs1 !== '0) begin
      errors++;
      $display("FAIL reset_b: done=%b sbs=%h want done=0 sbs=0", done1, sbs1);
    end
    $display("test_reset: done");
  endtask

  task automatic test_zero();
    int early = 0;
    apply_reset(8'd0, 8'd0);
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (done0 !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL zero_early_done: done seen high on %0d edges before 255, want 0", early);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || sbs0 !== '0) begin
      errors++;
      $display("FAIL zero_stream: done=%b sbs=%h want done=1 sbs=0", done0, sbs0);
    end
    $display("test_zero: a=0 done=%b ones=%0d", done0, $countones(sbs0));
  endtask

  task automatic test_full();
    apply_reset(8'd255, 8'd255);
    repeat (254) tick();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL full_early_done: done=%b at edge 254 want 0", done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || $countones(sbs0) != 255 || $countones(sbs1) != 255) begin
      errors++;
      $display("FAIL full_stream: done=%b ones_a=%0d ones_b=%0d want done=1 ones=255",
               done0, $countones(sbs0), $countones(sbs1));
    end
    $display("test_full: a=255 ones_a=%0d ones_b=%0d", $countones(sbs0), $countones(sbs1));
  endtask

  task automatic test_pair();
    int both;
    apply_reset(8'd128, 8'd128);
    repeat (255) tick();
    both = $countones(sbs0 & sbs1);
    checks++;
    if ($countones(sbs0) != 128 || $countones(sbs1) != 128) begin
      errors++;
      $display("FAIL pair_popcount: ones_a=%0d ones_b=%0d want 128", $countones(sbs0), $countones(sbs1));
    end
    checks++;
    if (sbs0 === sbs1) begin
      errors++;
      $display("FAIL pair_differ: streams identical %h, want different", sbs0);
    end
    checks++;
    if (both < 48 || both > 80) begin
      errors++;
      $display("FAIL pair_and: and_ones=%0d want 48..80", both);
    end
    checks++;
    if (sbs0 !== model_stream(8'hA5, 8'd128) || sbs1 !== model_stream(8'h01, 8'd128)) begin
      errors++;
      $display("FAIL pair_model: sbs_a=%h sbs_b=%h differ from model", sbs0, sbs1);
    end
    $display("test_pair: a=128 and_ones=%0d done=%b/%b", both, done0, done1);
  endtask

  task automatic test_sweep();
    logic [254:0] snap;
    logic [7:0]   vb;
    int           bad_hold;
    for (int v = 0; v < 256; v++) begin
      vb = 8'($urandom_range(255));
      apply_reset(8'(v), vb);
      repeat (255) tick();
      checks++;
      if (done0 !== 1'b1 || $countones(sbs0) != v) begin
        errors++;
        $display("FAIL sweep_popcount a=%0d: done=%b ones=%0d want done=1 ones=%0d",
                 v, done0, $countones(sbs0), v);
      end
      checks++;
      if (sbs0 !== model_stream(8'hA5, 8'(v)) || sbs1 !== model_stream(8'h01, vb)) begin
        errors++;
        $display("FAIL sweep_model a=%0d b=%0d: sbs_a=%h sbs_b=%h", v, vb, sbs0, sbs1);
      end
      if (v % 8 == 3) begin
        snap = sbs0;
        bad_hold = 0;
        for (int k = 0; k < 50; k++) begin
          tick();
          if (sbs0 !== snap || done0 !== 1'b1) bad_hold++;
        end
        checks++;
        if (bad_hold != 0) begin
          errors++;
          $display("FAIL sweep_hold a=%0d: %0d unstable cycles after done, want 0", v, bad_hold);
        end
      end
      $display("test_sweep: a=%0d ones=%0d b=%0d ones=%0d", v, $countones(sbs0), vb, $countones(sbs1));
    end
  endtask

  task automatic test_a_change();
    apply_reset(8'd200, 8'd200);
    repeat (100) tick();
    a0 = 8'd3;
    a1 = 8'd3;
    repeat (155) tick();
    checks++;
    if (done0 !== 1'b1 || $countones(sbs0) != 200 || sbs1 !== model_stream(8'h01, 8'd200)) begin
      errors++;
      $display("FAIL a_change: done=%b ones_a=%0d ones_b=%0d want done=1 ones=200",
               done0, $countones(sbs0), $countones(sbs1));
    end
    $display("test_a_change: ones_a=%0d ones_b=%0d", $countones(sbs0), $countones(sbs1));
  endtask

  task automatic test_reset_pulse();
    logic [7:0] v;
    v = 8'($urandom_range(1, 254));
    apply_reset(v, v);
    repeat (120) tick();
    apply_reset(v, v);
    checks++;
    if (done0 !== 1'b0 || sbs0 !== '0 || sbs1 !== '0) begin
      errors++;
      $display("FAIL pulse_clear: done=%b sbs_a=%h sbs_b=%h want done=0 sbs=0", done0, sbs0, sbs1);
    end
    repeat (254) tick();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_early_done: done=%b at edge 254 want 0", done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || sbs0 !== model_stream(8'hA5, v) || sbs1 !== model_stream(8'h01, v)) begin
      errors++;
      $display("FAIL pulse_restart a=%0d: done=%b sbs_a=%h want fresh %h",
               v, done0, sbs0, model_stream(8'hA5, v));
    end
    // Reset while already done behaves the same way.
    apply_reset(8'd77, 8'd77);
    checks++;
    if (done0 !== 1'b0 || sbs0 !== '0) begin
      errors++;
      $display("FAIL done_reset: done=%b sbs=%h want done=0 sbs=0", done0, sbs0);
    end
    repeat (255) tick();
    checks++;
    if (done0 !== 1'b1 || sbs0 !== model_stream(8'hA5, 8'd77)) begin
      errors++;
      $display("FAIL done_reset_rerun: done=%b ones=%0d want done=1 ones=77", done0, $countones(sbs0));
    end
    $display("test_reset_pulse: a=%0d ones=%0d", v, $countones(sbs0));
  endtask

  initial begin
    rst = 1'b0;
    a0  = 8'd0;
    a1  = 8'd0;
    test_reset();
    test_zero();
    test_full();
    test_pair();
    test_a_change();
    test_reset_pulse();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
